// File: rtl/lockstep_comparator_if.sv
// ---------------------------------------------------------------------------
// lockstep_comparator_if
//
// Bundles the compare inputs and the fault/self-test status outputs of the
// lockstep comparator. Clock and reset are kept outside as plain ports.
//
// Signals (direction seen from the comparator, i.e. the slave modport):
//   en                in   compare enable for functional comparisons
//   lead_bus          in   leading-core channels, ch i = [i*W +: W]
//   trail_bus         in   trailing-core channels, same packing
//   clr_req           in   clear sticky fault record and error counter
//   selftest_req      in   start comparator self-test (taken in IDLE only)
//   mismatch_now      out  a counted mismatch was sampled at the last edge
//   mismatch_latched  out  sticky OR of mismatch_now since reset/clear
//   mismatch_mask     out  sticky per-channel fault flags
//   first_ch          out  lowest failing channel of the first mismatch
//   err_count         out  saturating count of mismatch cycles
//   selftest_busy     out  self-test FSM not IDLE
//   selftest_done     out  one-cycle pulse at self-test end
//   selftest_pass     out  result of the last self-test
// ---------------------------------------------------------------------------
interface lockstep_comparator_if #(
  parameter int NCH   = 3,
  parameter int W     = 32,
  parameter int CNT_W = 8
);
  localparam int FCW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 en;
  logic [NCH*W-1:0]     lead_bus;
  logic [NCH*W-1:0]     trail_bus;
  logic                 clr_req;
  logic                 selftest_req;
  logic                 mismatch_now;
  logic                 mismatch_latched;
  logic [NCH-1:0]       mismatch_mask;
  logic [FCW-1:0]       first_ch;
  logic [CNT_W-1:0]     err_count;
  logic                 selftest_busy;
  logic                 selftest_done;
  logic                 selftest_pass;

  modport master (
    output en, lead_bus, trail_bus, clr_req, selftest_req,
    input  mismatch_now, mismatch_latched, mismatch_mask, first_ch,
           err_count, selftest_busy, selftest_done, selftest_pass
  );

  modport slave (
    input  en, lead_bus, trail_bus, clr_req, selftest_req,
    output mismatch_now, mismatch_latched, mismatch_mask, first_ch,
           err_count, selftest_busy, selftest_done, selftest_pass
  );
endinterface

// File: rtl/lockstep_comparator.sv
// ---------------------------------------------------------------------------
// lockstep_comparator
//
// Dual-core lockstep checker. NCH channels of W bits from a leading and a
// trailing core are compared after the leading bus has been delayed by DELAY
// cycles to line up with the trailing core. Keeps a sticky per-channel fault
// mask, a sticky summary flag, the first failing channel and a saturating
// error counter, and runs an on-demand self-test that flips bit 0 of every
// aligned leading channel for one cycle and checks that every channel
// comparator reports a difference.
//
// Ports:
//   clk   in   clock, all state on rising edge
//   rst   in   asynchronous, active-high; clears all state
//   bus   slave modport of lockstep_comparator_if (see that file)
//
// Parameters:
//   NCH    number of compared channels (1..16)
//   W      bits per channel
//   DELAY  trailing-core lag in cycles (0..7)
//   CNT_W  error counter width
// ---------------------------------------------------------------------------
module lockstep_comparator #(
  parameter int NCH   = 3,
  parameter int W     = 32,
  parameter int DELAY = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lockstep_comparator_if.slave  bus
);

  localparam int              FCW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0]      DELAY_L = 3'(DELAY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INJ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lowest set bit of a channel vector; returns 0 for an empty vector.
  function automatic logic [FCW-1:0] lowest_set(input logic [NCH-1:0] v);
    logic [FCW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = FCW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [NCH*W-1:0] aligned_s;
  logic [NCH*W-1:0] inj_s;
  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   fm_s;
  logic             any_s;
  logic             filled_s;
  logic             cmp_gate_s;

  logic [2:0]       fill_r;
  state_t           state_r;
  state_t           state_nxt_s;

  logic [NCH-1:0]   base_mask_s;
  logic             base_lat_s;
  logic [FCW-1:0]   base_first_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic [NCH-1:0]   mask_nxt_s;
  logic             lat_nxt_s;
  logic [FCW-1:0]   first_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic             now_r;
  logic             lat_r;
  logic [NCH-1:0]   mask_r;
  logic [FCW-1:0]   first_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  // -------------------------------------------------------------------------
  // Leading-bus delay line: the aligned value is the oldest stage, or the
  // live bus when the cores run without lag.
  // -------------------------------------------------------------------------
  generate
    if (DELAY == 0) begin : g_no_delay
      assign aligned_s = bus.lead_bus;
    end else begin : g_delay
      logic [NCH*W-1:0] lead_q_r [DELAY];

      // Shift the leading bus through DELAY register stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) begin
            lead_q_r[i] <= '0;
          end
        end else begin
          lead_q_r[0] <= bus.lead_bus;
          for (int i = 1; i < DELAY; i++) begin
            lead_q_r[i] <= lead_q_r[i-1];
          end
        end
      end

      assign aligned_s = lead_q_r[DELAY-1];
    end
  endgenerate

  // Fill counter: the delay line holds reset zeros until DELAY edges have
  // passed, so functional compares stay off until it saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r <= 3'd0;
    end else if (fill_r != DELAY_L) begin
      fill_r <= fill_r + 3'd1;
    end else begin
      fill_r <= fill_r;
    end
  end

  assign filled_s = (fill_r == DELAY_L);

  // -------------------------------------------------------------------------
  // Self-test FSM
  // -------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a request is only taken while idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.selftest_req) begin
          state_nxt_s = ST_INJ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INJ:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Comparison
  // -------------------------------------------------------------------------

  // Injection pattern: bit 0 of every channel while in INJ, so a healthy
  // comparator must see every channel differ.
  always_comb begin
    inj_s = '0;
    for (int i = 0; i < NCH; i++) begin
      inj_s[i*W] = (state_r == ST_INJ);
    end
  end

  // Per-channel raw comparator outputs.
  always_comb begin
    raw_s = '0;
    for (int i = 0; i < NCH; i++) begin
      raw_s[i] = ((aligned_s[i*W +: W] ^ inj_s[i*W +: W]) != bus.trail_bus[i*W +: W]);
    end
  end

  // The INJ cycle is never recorded as a functional fault.
  assign cmp_gate_s = bus.en & filled_s & (state_r != ST_INJ);
  assign fm_s       = raw_s & {NCH{cmp_gate_s}};
  assign any_s      = |fm_s;

  // Fault-record next state. Clear is applied first so that a mismatch on
  // the same edge survives the clear and re-captures first_ch.
  always_comb begin
    if (bus.clr_req) begin
      base_mask_s  = '0;
      base_lat_s   = 1'b0;
      base_first_s = '0;
      base_cnt_s   = '0;
    end else begin
      base_mask_s  = mask_r;
      base_lat_s   = lat_r;
      base_first_s = first_r;
      base_cnt_s   = cnt_r;
    end

    mask_nxt_s = base_mask_s | fm_s;
    lat_nxt_s  = base_lat_s | any_s;

    if (any_s && (base_cnt_s != CNT_MAX)) begin
      cnt_nxt_s = base_cnt_s + CNT_ONE;
    end else begin
      cnt_nxt_s = base_cnt_s;
    end

    if (!base_lat_s && any_s) begin
      first_nxt_s = lowest_set(fm_s);
    end else begin
      first_nxt_s = base_first_s;
    end
  end

  // Fault record and mismatch flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_r   <= 1'b0;
      lat_r   <= 1'b0;
      mask_r  <= '0;
      first_r <= '0;
      cnt_r   <= '0;
    end else begin
      now_r   <= any_s;
      lat_r   <= lat_nxt_s;
      mask_r  <= mask_nxt_s;
      first_r <= first_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Self-test status registers; busy/done are registered copies of the
  // next state so they line up with the state register. Pass is captured
  // from the INJ cycle regardless of enable or fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_DONE);
      if (state_r == ST_INJ) begin
        pass_r <= &raw_s;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign bus.mismatch_now     = now_r;
  assign bus.mismatch_latched = lat_r;
  assign bus.mismatch_mask    = mask_r;
  assign bus.first_ch         = first_r;
  assign bus.err_count        = cnt_r;
  assign bus.selftest_busy    = busy_r;
  assign bus.selftest_done    = done_r;
  assign bus.selftest_pass    = pass_r;

endmodule

// File: tb/tb_lockstep_comparator.sv
// ---------------------------------------------------------------------------
// tb_lockstep_comparator
//
// Directed, table-driven bench for lockstep_comparator with NCH=3, W=32,
// DELAY=2, CNT_W=4. Each row gives the controls and trail corruption for one
// clock edge plus the hand-computed outputs expected after that edge. The
// leading stream varies every cycle and the clean trailing stream is the
// leading stream two cycles earlier, so a wrong alignment shows up as
// spurious mismatches. A hand-written sequence covers the asynchronous reset
// in the middle of a self-test.
// ---------------------------------------------------------------------------
module tb_lockstep_comparator;

  localparam int NCH   = 3;
  localparam int W     = 32;
  localparam int DELAY = 2;
  localparam int CNT_W = 4;

  typedef struct {
    logic       en;
    logic       clr;
    logic       st;
    logic [2:0] badm;   // trail channel forced to 32'hDEADBEEF
    logic [2:0] flipm;  // trail channel = aligned lead ^ 1
    logic       now;
    logic       lat;
    logic [2:0] mask;
    logic [1:0] first;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int n_bad = 0;
  int k     = 0;

  vec_t tab1[$];
  vec_t tab2[$];

  lockstep_comparator_if #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) bus ();

  lockstep_comparator #(
    .NCH(NCH), .W(W), .DELAY(DELAY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gen(input int step, input int ch);
    return (32'h1357_9BDF * step) + (32'h0F0F_0000 * ch) + 32'h0000_0011;
  endfunction

  function automatic vec_t mk(input logic en, input logic clr, input logic st,
                              input logic [2:0] badm, input logic [2:0] flipm,
                              input logic now, input logic lat, input logic [2:0] mask,
                              input logic [1:0] first, input logic [3:0] cnt,
                              input logic busy, input logic done, input logic pass);
    vec_t v;
    v.en = en; v.clr = clr; v.st = st; v.badm = badm; v.flipm = flipm;
    v.now = now; v.lat = lat; v.mask = mask; v.first = first; v.cnt = cnt;
    v.busy = busy; v.done = done; v.pass = pass;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".now"},   32'(bus.mismatch_now),     32'(v.now));
    chk({tag, ".lat"},   32'(bus.mismatch_latched), 32'(v.lat));
    chk({tag, ".mask"},  32'(bus.mismatch_mask),    32'(v.mask));
    chk({tag, ".first"}, 32'(bus.first_ch),         32'(v.first));
    chk({tag, ".cnt"},   32'(bus.err_count),        32'(v.cnt));
    chk({tag, ".busy"},  32'(bus.selftest_busy),    32'(v.busy));
    chk({tag, ".done"},  32'(bus.selftest_done),    32'(v.done));
    chk({tag, ".pass"},  32'(bus.selftest_pass),    32'(v.pass));
  endtask

  task automatic idle_inputs();
    bus.en           = 1'b0;
    bus.clr_req      = 1'b0;
    bus.selftest_req = 1'b0;
  endtask

  // Drive one row, clock one edge, check one cycle later.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] t;
    k++;
    for (int ch = 0; ch < NCH; ch++) begin
      bus.lead_bus[ch*W +: W] = gen(k, ch);
      t = (k >= 3) ? gen(k - 2, ch) : 32'h0000_0000;
      if (v.badm[ch])  t = 32'hDEAD_BEEF;
      if (v.flipm[ch]) t = t ^ 32'h0000_0001;
      bus.trail_bus[ch*W +: W] = t;
    end
    bus.en           = v.en;
    bus.clr_req      = v.clr;
    bus.selftest_req = v.st;
    @(posedge clk);
    #1;
    chk_all(tag, v);
  endtask

  initial begin
    vec_t z;
    // ---------------- table 1 ----------------
    // Clean aligned streams.
    for (int i = 0; i < 20; i++)
      tab1.push_back(mk(1,0,0, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    // Single ch1 fault, then clean cycles with the record held.
    tab1.push_back(mk(1,0,0, 3'b010,3'b000, 1,1,3'b010,2'd1,4'd1, 0,0,0));
    for (int i = 0; i < 10; i++)
      tab1.push_back(mk(1,0,0, 3'b000,3'b000, 0,1,3'b010,2'd1,4'd1, 0,0,0));
    // Clear alone.
    tab1.push_back(mk(1,1,0, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    // Saturation on ch0+ch2.
    for (int i = 0; i < 20; i++)
      tab1.push_back(mk(1,0,0, 3'b101,3'b000, 1,1,3'b101,2'd0,
                        (i < 15) ? 4'(i + 1) : 4'd15, 0,0,0));
    // Clear on the same edge as a ch2 fault: the fault wins.
    tab1.push_back(mk(1,1,0, 3'b100,3'b000, 1,1,3'b100,2'd2,4'd1, 0,0,0));
    tab1.push_back(mk(1,1,0, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    // Self-test with en=0; requests in INJ/DONE are ignored.
    tab1.push_back(mk(0,0,1, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 1,0,0));
    tab1.push_back(mk(0,0,1, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 1,1,1));
    tab1.push_back(mk(0,0,1, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,1));
    tab1.push_back(mk(0,0,0, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,1));
    // Self-test with raw[0] forced low during INJ, en=1: no functional record.
    tab1.push_back(mk(1,0,1, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 1,0,1));
    tab1.push_back(mk(1,0,0, 3'b000,3'b001, 0,0,3'b000,2'd0,4'd0, 1,1,0));
    tab1.push_back(mk(1,0,0, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    // Disabled compare ignores faults.
    tab1.push_back(mk(0,0,0, 3'b111,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    // Set up latched=1 and enter INJ for the reset sequence.
    tab1.push_back(mk(1,0,0, 3'b001,3'b000, 1,1,3'b001,2'd0,4'd1, 0,0,0));
    tab1.push_back(mk(1,0,1, 3'b000,3'b000, 0,1,3'b001,2'd0,4'd1, 1,0,0));
    // ---------------- table 2 (after reset release) ----------------
    tab2.push_back(mk(1,0,0, 3'b010,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    tab2.push_back(mk(1,0,0, 3'b010,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0));
    tab2.push_back(mk(1,0,0, 3'b010,3'b000, 1,1,3'b010,2'd1,4'd1, 0,0,0));
    tab2.push_back(mk(1,0,0, 3'b000,3'b000, 0,1,3'b010,2'd1,4'd1, 0,0,0));

    z = mk(0,0,0, 3'b000,3'b000, 0,0,3'b000,2'd0,4'd0, 0,0,0);

    // Power-on reset.
    idle_inputs();
    bus.lead_bus  = '0;
    bus.trail_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", z);
    rst = 1'b0;
    k   = 0;

    for (int i = 0; i < tab1.size(); i++)
      apply(tab1[i], $sformatf("t1[%0d]", i));

    // Asynchronous reset while latched and in INJ: outputs clear at once.
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk_all("rst_async", z);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold[%0d].done", i), 32'(bus.selftest_done), 32'd0);
      chk($sformatf("rst_hold[%0d].busy", i), 32'(bus.selftest_busy), 32'd0);
    end
    rst = 1'b0;
    k   = 0;

    for (int i = 0; i < tab2.size(); i++)
      apply(tab2[i], $sformatf("t2[%0d]", i));

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule

// File: doc/lockstep_comparator.md
# lockstep_comparator

Parametrised dual-core lockstep checker for the FuSa CPU. It compares NCH observable channels of W bits each from a leading and a trailing core. The trailing core runs DELAY cycles behind, so the leading bus is time-aligned through an internal delay line. It keeps a per-channel sticky fault record, a first-failing-channel capture and a saturating error counter, and provides an on-demand comparator self-test. It supersedes the fixed three-signal comparator inside lockstep_top.

## Interface
- NCH, 3: number of compared channels (1..16)
- W, 32: bits per channel
- DELAY, 2: trailing-core lag in cycles (0..7)
- CNT_W, 8: error counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  compare enable for functional comparisons
- lead_bus  in  NCH*W  leading-core channels, ch i = bits [i*W +: W]
- trail_bus  in  NCH*W  trailing-core channels, same packing
- clr_req  in  1  clear sticky record and counter
- selftest_req  in  1  start comparator self-test (honoured in IDLE only)
- mismatch_now  out  1  registered; a counted mismatch was sampled at the last edge
- mismatch_latched  out  1  sticky OR of mismatch_now since reset/clear
- mismatch_mask  out  NCH  sticky per-channel fault flags
- first_ch  out  max(1,clog2(NCH))  lowest failing channel of the first mismatch since reset/clear
- err_count  out  CNT_W  count of mismatch cycles, saturating
- selftest_busy  out  1  FSM not IDLE
- selftest_done  out  1  one-cycle pulse at self-test end
- selftest_pass  out  1  result of the last self-test; held until the next self-test

## Operation
- Delay line: lead_bus passes through DELAY registers lead_q[0..DELAY-1]. The aligned leading value is lead_q[DELAY-1]. With DELAY=0 the aligned value is lead_bus directly.
- Fill counter: counts edges after reset release up to DELAY. Functional compares are allowed only when fill==DELAY.
- Raw compare vector: raw[i] = (aligned_lead_i ^ inj) != trail_i, where inj = 1 in bit 0 of every channel while the FSM is in INJ, else 0.
- Functional mismatch vector: fm[i] = raw[i] & en & filled & (state != INJ).
- Each edge:
  - mismatch_now <= |fm.
  - mismatch_mask <= mask | fm.
  - mismatch_latched <= latched | (|fm).
  - err_count increments by 1 if |fm, saturating at 2^CNT_W-1.
  - first_ch loads the lowest i with fm[i]=1 only when latched is 0 and |fm is 1.
- clr_req sampled at an edge zeroes mask, latched, first_ch and err_count. A same-edge fm is applied after the clear, so the mismatch wins: latched=1, mask=fm, count=1, first_ch recaptured. mismatch_now is unaffected by clr_req.
- Self-test FSM, states IDLE, INJ, DONE:
  - IDLE -> INJ when selftest_req is sampled at an edge.
  - INJ -> DONE at the next edge. That edge captures selftest_pass <= &raw. The capture ignores en and fill.
  - DONE -> IDLE at the next edge.
  - selftest_done = (state==DONE). selftest_busy = (state!=IDLE).
  - selftest_req is ignored outside IDLE.
- Functional compares are suspended for the single INJ cycle. A genuine fault present only in that cycle is not recorded; this is an accepted limitation.
- clr_req during a self-test is honoured normally.

## Timing
- Reset values: every output 0, FSM IDLE, fill 0, delay line 0.
- Reset is asynchronous and takes effect immediately, including mid self-test, where it aborts the test with no done pulse.
- Alignment: the lead sample presented before edge E0 is compared with the trail sample presented before edge E0+DELAY.
- Fault latency: a differing pair sampled at edge E gives mismatch_now, latched, mask, count and first_ch updated after E, in the same cycle.
- Self-test: req sampled at E leads to busy after E, done high for the cycle after E+1 with pass valid from E+1, and IDLE after E+2.
- No functional compare is performed at edges 1..DELAY after reset release.

## Test plan
- NCH=3, W=32, DELAY=2: trail = lead delayed by 2, 20 cycles -> mismatch_now=0, latched=0, err_count=0 throughout.
- Force trail ch1 to 0xDEADBEEF for one sampled edge -> mismatch_now=1 for one cycle; latched=1, mask=3'b010, first_ch=1, count=1. All remain unchanged over 10 further clean cycles.
- CNT_W=4, 20 consecutive mismatching edges on ch0 and ch2 -> err_count=15 (saturated), mask=3'b101, first_ch=0.
- clr_req alone -> latched=0, mask=0, count=0. clr_req on the same edge as a ch2 mismatch -> latched=1, mask=3'b100, first_ch=2, count=1.
- selftest_req with clean streams and en=0 -> busy after the req edge, done pulse one cycle later, pass=1, latched stays 0. Repeat with raw[0] forced to 0 -> pass=0.
- Assert reset while latched=1 and FSM=INJ -> all outputs 0 immediately, no done pulse. Then inject a mismatch at edges 1-2 after release -> ignored. A mismatch at edge 3 -> flagged.
